// File: rtl/fifo_push_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// Packet lock is built only with FIFO_PUSH_ARB_PKT_LOCK_EN.
package fifo_push_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_push_arb_rr_prio_select.sv
// Round-robin priority select: first valid at or after the pointer.
// Pure combinational; wraps modulo N.
module rr_prio_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_oh,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    logic [IW-1:0] w_j;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      j   = (int'(i_ptr) + i) % N;
      w_j = IW'(j);
      if (!o_any && i_valid[w_j]) begin
        o_any       = 1'b1;
        o_gnt_oh[w_j] = 1'b1;
        o_gnt_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// N-to-1 round-robin push arbiter in front of a FIFO, with flush.
// Define FIFO_PUSH_ARB_PKT_LOCK_EN to hold the grant across a packet.
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = idx_w(NUM_IN)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_IN-1:0]            in_valid_i,
  output logic [NUM_IN-1:0]            in_ready_o,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]            in_last_i,
  input  logic                         fifo_full_i,
  output logic                         fifo_push_o,
  output logic [DATA_WIDTH-1:0]        fifo_data_o,
  output logic                         fifo_flush_o,
  input  logic                         flush_req_i,
  output logic                         flush_ack_o,
  output logic [IDX_W-1:0]             gnt_idx_o
);

  state_e            r_state;
  state_e            w_next;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_gidx;
  logic [IDX_W-1:0]  w_rr_nxt;
  logic [NUM_IN-1:0] w_sel_oh;
  logic [NUM_IN-1:0] w_goh;
  logic              w_any;
  logic              w_push;

`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
  logic [IDX_W-1:0]  r_lock_idx;
  logic              w_last;
`else
  logic              w_unused;
  assign w_unused = ^in_last_i;
`endif

  rr_prio_select #(
    .N  (NUM_IN),
    .IW (IDX_W)
  ) u_sel (
    .i_valid   (in_valid_i),
    .i_ptr     (r_rr),
    .o_gnt_oh  (w_sel_oh),
    .o_gnt_idx (w_sel_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_gidx = w_sel_idx;
    w_goh  = '0;
    case (r_state)
      ST_ARB: begin
        if (!flush_req_i && w_any) w_goh = w_sel_oh;
      end
`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
      ST_LOCK: begin
        w_gidx = r_lock_idx;
        w_goh  = {{(NUM_IN-1){1'b0}}, 1'b1} << r_lock_idx;
      end
`endif
      default: ;
    endcase
    if (rst_i) w_goh = '0;
  end

  assign in_ready_o  = w_goh & {NUM_IN{~fifo_full_i}};
  assign w_push      = |(in_ready_o & in_valid_i);
  assign fifo_push_o = w_push;

  always_comb begin
    fifo_data_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_goh[i]) fifo_data_o = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_rr_nxt = (w_gidx == IDX_W'(NUM_IN-1)) ? '0 : w_gidx + 1'b1;

`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
  assign w_last = in_last_i[w_gidx];
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARB: begin
        if (flush_req_i) w_next = ST_FLUSH;
`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
        else if (w_push && !w_last) w_next = ST_LOCK;
`endif
      end
`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
      ST_LOCK: begin
        if (w_push && w_last)
          w_next = flush_req_i ? ST_FLUSH : ST_ARB;
      end
`endif
      default: w_next = ST_ARB;
    endcase
  end

  assign fifo_flush_o = (r_state == ST_FLUSH) & ~rst_i;
  assign flush_ack_o  = fifo_flush_o;
  assign gnt_idx_o    = r_gnt_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_ARB;
      r_rr      <= '0;
      r_gnt_idx <= '0;
`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
      r_lock_idx <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_rr      <= w_rr_nxt;
        r_gnt_idx <= w_gidx;
`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
        r_lock_idx <= w_gidx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb (4 requesters, 32-bit payload).
// Lock scenarios run when FIFO_PUSH_ARB_PKT_LOCK_EN is defined.
module tb_fifo_push_arb;
  import fifo_push_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      in_valid_i;
  logic [N-1:0]      in_ready_o;
  logic [N*DW-1:0]   in_data_i;
  logic [N-1:0]      in_last_i;
  logic              fifo_full_i;
  logic              fifo_push_o;
  logic [DW-1:0]     fifo_data_o;
  logic              fifo_flush_o;
  logic              flush_req_i;
  logic              flush_ack_o;
  logic [IW-1:0]     gnt_idx_o;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_push_arb #(
    .NUM_IN     (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_flush_o (fifo_flush_o),
    .flush_req_i  (flush_req_i),
    .flush_ack_o  (flush_ack_o),
    .gnt_idx_o    (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] dat(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = '0;
    in_last_i   = '0;
    fifo_full_i = 1'b0;
    flush_req_i = 1'b0;
    for (int i = 0; i < N; i++) in_data_i[i*DW +: DW] = dat(i);

    // reset holds everything quiet
    cyc();
    cyc();
    in_valid_i = 4'hF;
    #1;
    chk("rst_ready", 64'(in_ready_o), 64'h0);
    chk("rst_push", 64'(fifo_push_o), 64'h0);
    chk("rst_flush", 64'(fifo_flush_o), 64'h0);
    chk("rst_ack", 64'(flush_ack_o), 64'h0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt_idx_o), 64'h0);
    chk("rst_rr", 64'(dut.r_rr), 64'h0);

    // all valid: strict rotation
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rot_ready", 64'(in_ready_o), 64'(4'b0001 << (i % 4)));
      chk("rot_push", 64'(fifo_push_o), 64'h1);
      chk("rot_data", 64'(fifo_data_o), 64'(dat(i % 4)));
      cyc();
      chk("rot_gnt", 64'(gnt_idx_o), 64'(i % 4));
    end
    in_valid_i = '0;
    chk("rot_rr", 64'(dut.r_rr), 64'h0);

    // bring rr to 2, then 1010 -> 3 then 1
    in_valid_i = 4'b0010;
    #1;
    chk("pre_ready", 64'(in_ready_o), 64'b0010);
    cyc();
    chk("pre_rr", 64'(dut.r_rr), 64'h2);
    in_valid_i = 4'b1010;
    #1;
    chk("skip_ready3", 64'(in_ready_o), 64'b1000);
    chk("skip_data3", 64'(fifo_data_o), 64'(dat(3)));
    cyc();
    #1;
    chk("skip_ready1", 64'(in_ready_o), 64'b0010);
    cyc();
    in_valid_i = '0;
    chk("skip_rr", 64'(dut.r_rr), 64'h2);
    chk("skip_gnt", 64'(gnt_idx_o), 64'h1);

    // full stalls without rotating
    in_valid_i  = 4'hF;
    fifo_full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_push", 64'(fifo_push_o), 64'h0);
      chk("full_ready", 64'(in_ready_o), 64'h0);
      cyc();
      chk("full_rr", 64'(dut.r_rr), 64'h2);
    end
    fifo_full_i = 1'b0;
    #1;
    chk("resume_ready", 64'(in_ready_o), 64'b0100);
    chk("resume_push", 64'(fifo_push_o), 64'h1);
    cyc();
    chk("resume_gnt", 64'(gnt_idx_o), 64'h2);
    chk("resume_rr", 64'(dut.r_rr), 64'h3);

    // single flush pulse
    flush_req_i = 1'b1;
    #1;
    chk("fr_push", 64'(fifo_push_o), 64'h0);
    chk("fr_ready", 64'(in_ready_o), 64'h0);
    chk("fr_data", 64'(fifo_data_o), 64'h0);
    chk("fr_flush", 64'(fifo_flush_o), 64'h0);
    cyc();
    flush_req_i = 1'b0;
    #1;
    chk("fl_flush", 64'(fifo_flush_o), 64'h1);
    chk("fl_ack", 64'(flush_ack_o), 64'h1);
    chk("fl_push", 64'(fifo_push_o), 64'h0);
    chk("fl_ready", 64'(in_ready_o), 64'h0);
    cyc();
    #1;
    chk("fl_done_flush", 64'(fifo_flush_o), 64'h0);
    chk("fl_done_ack", 64'(flush_ack_o), 64'h0);
    chk("fl_done_ready", 64'(in_ready_o), 64'b1000);
    cyc();
    in_valid_i = '0;
    chk("fl_done_rr", 64'(dut.r_rr), 64'h0);

    // held flush request restarts after each ack
    flush_req_i = 1'b1;
    #1;
    chk("hold_ack0", 64'(flush_ack_o), 64'h0);
    cyc();
    #1;
    chk("hold_ack1", 64'(flush_ack_o), 64'h1);
    cyc();
    #1;
    chk("hold_ack2", 64'(flush_ack_o), 64'h0);
    cyc();
    #1;
    chk("hold_ack3", 64'(flush_ack_o), 64'h1);
    flush_req_i = 1'b0;
    cyc();
    #1;
    chk("hold_ack4", 64'(flush_ack_o), 64'h0);

`ifdef FIFO_PUSH_ARB_PKT_LOCK_EN
    // 3-beat packet from 1 while 2 waits, flush raised mid-packet
    in_valid_i = 4'b0110;
    in_last_i  = 4'b0000;
    #1;
    chk("lk_b1", 64'(in_ready_o), 64'b0010);
    cyc();
    flush_req_i = 1'b1;
    #1;
    chk("lk_b2", 64'(in_ready_o), 64'b0010);
    chk("lk_b2_data", 64'(fifo_data_o), 64'(dat(1)));
    chk("lk_b2_ack", 64'(flush_ack_o), 64'h0);
    cyc();
    in_last_i = 4'b0010;
    #1;
    chk("lk_b3", 64'(in_ready_o), 64'b0010);
    chk("lk_b3_ack", 64'(flush_ack_o), 64'h0);
    cyc();
    in_last_i = 4'b0000;
    #1;
    chk("lk_fl_ack", 64'(flush_ack_o), 64'h1);
    chk("lk_fl_ready", 64'(in_ready_o), 64'h0);
    flush_req_i = 1'b0;
    cyc();
    in_last_i = 4'b0100;
    #1;
    chk("lk_next2", 64'(in_ready_o), 64'b0100);
    cyc();
    chk("lk_rr", 64'(dut.r_rr), 64'h3);

    // reset while locked
    in_valid_i = 4'b0010;
    in_last_i  = 4'b0000;
    #1;
    chk("lr_grant", 64'(in_ready_o), 64'b0010);
    cyc();
    chk("lr_locked", 64'(dut.r_state), 64'(ST_LOCK));
    rst_i = 1'b1;
    #1;
    chk("lr_rst_ready", 64'(in_ready_o), 64'h0);
    cyc();
    rst_i      = 1'b0;
    in_valid_i = 4'b0100;
    #1;
    chk("lr_state", 64'(dut.r_state), 64'(ST_ARB));
    chk("lr_rr", 64'(dut.r_rr), 64'h0);
    chk("lr_ack", 64'(flush_ack_o), 64'h0);
    chk("lr_unlocked", 64'(in_ready_o), 64'b0100);
    cyc();
    in_valid_i = '0;
    #1;
    chk("lr_ack2", 64'(flush_ack_o), 64'h0);
`else
    // last ignored: re-arbitrate every beat
    in_valid_i = 4'b0110;
    in_last_i  = 4'b0000;
    #1;
    chk("nl_b1", 64'(in_ready_o), 64'b0010);
    cyc();
    #1;
    chk("nl_b2", 64'(in_ready_o), 64'b0100);
    cyc();
    #1;
    chk("nl_b3", 64'(in_ready_o), 64'b0010);
    cyc();
    in_valid_i = '0;

    // reset mid-flush: no ack
    flush_req_i = 1'b1;
    cyc();
    chk("rf_in_flush", 64'(dut.r_state), 64'(ST_FLUSH));
    rst_i       = 1'b1;
    flush_req_i = 1'b0;
    #1;
    chk("rf_ack", 64'(flush_ack_o), 64'h0);
    chk("rf_flush", 64'(fifo_flush_o), 64'h0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("rf_state", 64'(dut.r_state), 64'(ST_ARB));
    chk("rf_rr", 64'(dut.r_rr), 64'h0);
    chk("rf_ack2", 64'(flush_ack_o), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-003 SHALL have localparameter IDX_W = $clog2(NUM_IN), never overridden.
REQ-004 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have in_valid_i  input  NUM_IN  per-requester beat valid.
REQ-007 SHALL have in_ready_o  output  NUM_IN  per-requester beat accepted.
REQ-008 SHALL have in_data_i  input  NUM_IN x DATA_WIDTH  per-requester payload.
REQ-009 SHALL have in_last_i  input  NUM_IN  last beat of packet; ignored without lock feature.
REQ-010 SHALL have fifo_full_i  input  1  full flag of the downstream FIFO.
REQ-011 SHALL have fifo_push_o  output  1  push strobe to the downstream FIFO.
REQ-012 SHALL have fifo_data_o  output  DATA_WIDTH  payload to the downstream FIFO.
REQ-013 SHALL have fifo_flush_o  output  1  flush strobe to the downstream FIFO.
REQ-014 SHALL have flush_req_i  input  1  level request to flush the FIFO.
REQ-015 SHALL have flush_ack_o  output  1  one-cycle flush completion pulse.
REQ-016 SHALL have gnt_idx_o  output  IDX_W  index of the current or last granted requester.

Function
REQ-017 SHALL implement states ARB, LOCK (only with the lock feature) and FLUSH.
REQ-018 SHALL, in ARB, grant the lowest index >= rr_q with in_valid_i set, wrapping modulo NUM_IN.
REQ-019 SHALL assert in_ready_o only for the granted index, and only when fifo_full_i=0 and flush_req_i=0.
REQ-020 SHALL drive fifo_push_o = in_valid_i[g] & in_ready_o[g], combinationally, with zero cycles of latency.
REQ-021 SHALL drive fifo_data_o = in_data_i[g] whenever a grant exists, and all zeros otherwise.
REQ-022 SHALL, on each accepted beat from index k, load rr_q with k+1, wrapping from NUM_IN-1 to 0.
REQ-023 SHALL NOT change rr_q when no beat is accepted; a full FIFO stalls arbitration without rotating.
REQ-024 SHALL NOT require in_valid_i to stay stable while stalled; grant is recomputed every cycle in ARB.
REQ-025 SHALL, in ARB with flush_req_i=1, suppress all grants and enter FLUSH the next cycle.
REQ-026 SHALL, in FLUSH, assert fifo_flush_o=1 and flush_ack_o=1 for exactly one cycle, grant nothing, then return to ARB.
REQ-027 SHALL start a new flush sequence if flush_req_i is still high in the cycle after flush_ack_o.
REQ-028 SHALL update gnt_idx_o to k on every accepted beat and hold it otherwise.

Reset
REQ-029 SHALL, with rst_i=1 at a clock edge, set state=ARB, rr_q=0, gnt_idx_o=0 and clear any lock.
REQ-030 SHALL hold in_ready_o, fifo_push_o, fifo_flush_o and flush_ack_o at 0 while rst_i=1.
REQ-031 SHALL, on reset mid-packet or mid-flush, abandon the operation with no ack pulse.

Configuration
REQ-032 SHALL compile the packet-lock feature only when macro FIFO_PUSH_ARB_PKT_LOCK_EN is defined.
REQ-033 SHALL, with the macro defined, enter LOCK when a beat with in_last_i=0 is accepted from index k.
REQ-034 SHALL, in LOCK, grant only index k, still gated by fifo_full_i, regardless of flush_req_i.
REQ-035 SHALL, in LOCK, return to ARB (or FLUSH if flush_req_i=1) after a beat with in_last_i=1 is accepted; rr_q=k+1.
REQ-036 SHALL, without the macro, omit LOCK, ignore in_last_i and re-arbitrate every beat.

Structure
REQ-037 SHALL place the state enum and the IDX_W helper function in shared package fifo_push_arb_pkg.
REQ-038 SHALL use one combinational sub-module rr_prio_select (valid vector plus pointer in, grant one-hot and index out).

Verification
REQ-039 Bench SHALL cover: all 4 valid, full=0, 8 cycles -> grants 0,1,2,3,0,1,2,3; one push per cycle.
REQ-040 Bench SHALL cover: valid=4'b1010 with rr_q=2 -> grant 3, then 1; rr_q ends at 2.
REQ-041 Bench SHALL cover: full=1 for 3 cycles with valid=4'b1111 -> no push, rr_q unchanged, then grant resumes at the same index.
REQ-042 Bench SHALL cover: flush_req_i pulse in ARB -> fifo_flush_o and flush_ack_o high for exactly 1 cycle, one cycle later; no push in between.
REQ-043 Bench SHALL cover: with lock, req 1 sends a 3-beat packet while req 2 is valid -> beats 1,1,1 and then 2; a flush raised mid-packet acks only after the last beat.
REQ-044 Bench SHALL cover: rst_i asserted in LOCK -> the next cycle is ARB with rr_q=0 and no flush_ack_o.
